// File: rtl/moonbase_pkg.sv
// Shared definitions for the moonbase nibble CPU.
// Contents: opcode and misc-subcode constants, bus phase / exec state / ALU op
// enums, io_out bit positions, and helpers for operand addressing and ALU op
// selection.
package moonbase_pkg;

  // First-nibble opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDM  = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_MISC = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADI  = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'ha;
  localparam logic [3:0] OP_STM  = 4'hb;
  localparam logic [3:0] OP_LDX  = 4'hc;
  localparam logic [3:0] OP_JNZ  = 4'hd;
  localparam logic [3:0] OP_JZ   = 4'he;
  localparam logic [3:0] OP_JMP  = 4'hf;

  // Second nibble of OP_MISC
  localparam logic [3:0] MISC_TYX = 4'h0;
  localparam logic [3:0] MISC_TXY = 4'h1;
  localparam logic [3:0] MISC_SWP = 4'h2;
  localparam logic [3:0] MISC_RET = 4'h3;
  localparam logic [3:0] MISC_TST = 4'h8;

  // io_out bit positions outside the address/data fields
  localparam int unsigned IO_ADDR_PHASE = 7;
  localparam int unsigned IO_WE_N       = 5;
  localparam int unsigned IO_STB_N      = 4;

  typedef enum logic [1:0] {PH_ADDR, PH_D0, PH_D1} bus_phase_e;
  typedef enum logic [1:0] {EX_OP, EX_ARG1, EX_ARG2, EX_DATA} exec_state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_PASS} alu_op_e;

  // o(r) operand: bit 3 picks Y over X, bits 2:0 are the offset; 7-bit wrap.
  function automatic logic [6:0] operand_ea(logic [3:0] nib, logic [6:0] x, logic [6:0] y);
    logic [6:0] base;
    base = nib[3] ? y : x;
    return base + {4'b0000, nib[2:0]};
  endfunction

  function automatic alu_op_e alu_op_for(logic [3:0] opcode);
    case (opcode)
      OP_SUB:         return ALU_SUB;
      OP_OR:          return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_XOR:         return ALU_XOR;
      OP_LDM, OP_LDI: return ALU_PASS;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/moonbase_alu.sv
// Combinational 4-bit ALU for the moonbase CPU, arithmetic mod 16, no flags.
// Ports: op (operation), a (accumulator), b (memory/immediate operand), y (result).
module moonbase_alu
  import moonbase_pkg::*;
(
  input  alu_op_e    op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_XOR:  y = a ^ b;
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/moonbase_cpu8_core.sv
// moonbase_cpu8_core: nibble-coded CPU on a pin-multiplexed 3-phase external bus.
// Ports:
//   io_in  [0]=clk, [1]=rst_n (async, active low), [5:2]=bus read nibble, [7:6] unused
//   io_out [7]=address phase; [6:0]=address in ADDR phase,
//          otherwise [5]=mem WE_n, [4]=IO strobe_n, [3:0]=write data
// Parameter MAX_COUNT: timer period in clocks.
// Optional feature: define MOONBASE_TIMER_EN to add the free-running timer whose
// sticky wrap flag is read by the tst instruction.
module moonbase_cpu8_core
  import moonbase_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 100
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst_n;
  logic [3:0] bus_nib;
  assign clk     = io_in[0];
  assign rst_n   = io_in[1];
  assign bus_nib = io_in[5:2];

  bus_phase_e  phase_q, phase_d;
  exec_state_e state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  arg_q, arg_d;
  logic [3:0]  rd_q, rd_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [6:0]  pc_q, pc_d;
  logic [6:0]  ea_q, ea_d;
  logic [6:0]  stk_q [4];
  logic [6:0]  stk_d [4];
  logic [1:0]  sp_q, sp_d;

  logic [6:0]  pc_inc;
  logic [1:0]  sp_m1;
  logic [6:0]  target;
  logic [6:0]  bus_addr;
  logic [3:0]  alu_y;
  logic        tst_clr;
  logic        tf_bit;

  assign pc_inc = pc_q + 7'd1;
  assign sp_m1  = sp_q - 2'd1;
  assign target = {arg_q[2:0], rd_q};

  moonbase_alu u_alu (
    .op (alu_op_for(op_q)),
    .a  (a_q),
    .b  (rd_q),
    .y  (alu_y)
  );

  always_comb begin
    phase_d = phase_q;
    state_d = state_q;
    a_d     = a_q;
    op_d    = op_q;
    arg_d   = arg_q;
    rd_d    = rd_q;
    x_d     = x_q;
    y_d     = y_q;
    pc_d    = pc_q;
    ea_d    = ea_q;
    stk_d   = stk_q;
    sp_d    = sp_q;
    tst_clr = 1'b0;

    case (phase_q)
      PH_ADDR: phase_d = PH_D0;
      PH_D0:   phase_d = PH_D1;
      default: phase_d = PH_ADDR;
    endcase

    // Low nibble is captured at the end of D0; all decode happens at the end of D1.
    if (phase_q == PH_D0) begin
      rd_d = bus_nib;
      if (state_q == EX_DATA && op_q == OP_IN) a_d = bus_nib;
    end

    if (phase_q == PH_D1) begin
      case (state_q)
        EX_OP: begin
          op_d    = rd_q;
          pc_d    = pc_inc;
          state_d = EX_ARG1;
        end
        EX_ARG1: begin
          pc_d    = pc_inc;
          state_d = EX_OP;
          case (op_q)
            OP_MISC: begin
              case (rd_q)
                MISC_TYX: y_d = x_q;
                MISC_TXY: x_d = y_q;
                MISC_SWP: begin
                  x_d = y_q;
                  y_d = x_q;
                end
                MISC_RET: begin
                  // Pointer is circular, so an empty stack yields a stale entry.
                  pc_d = stk_q[sp_m1];
                  sp_d = sp_m1;
                end
                MISC_TST: begin
                  a_d     = {3'b000, tf_bit};
                  tst_clr = 1'b1;
                end
                default: ;
              endcase
            end
            OP_LDI, OP_ADI: a_d = alu_y;
            OP_LDX, OP_JNZ, OP_JZ, OP_JMP: begin
              arg_d   = rd_q;
              state_d = EX_ARG2;
            end
            default: begin
              ea_d    = operand_ea(rd_q, x_q[6:0], y_q[6:0]);
              state_d = EX_DATA;
            end
          endcase
        end
        EX_ARG2: begin
          pc_d    = pc_inc;
          state_d = EX_OP;
          case (op_q)
            OP_LDX: x_d = {arg_q, rd_q};
            OP_JNZ: if (a_q != '0) pc_d = target;
            OP_JZ:  if (a_q == '0) pc_d = target;
            default: begin
              if (arg_q[3]) begin
                stk_d[sp_q] = pc_inc;
                sp_d        = sp_q + 2'd1;
              end
              pc_d = target;
            end
          endcase
        end
        default: begin
          state_d = EX_OP;
          if (op_q <= OP_LDM) a_d = alu_y;
        end
      endcase
    end
  end

  always_comb begin
    io_out   = '0;
    bus_addr = (state_q == EX_DATA) ? ea_q : pc_q;
    if (phase_q == PH_ADDR) begin
      io_out = {1'b1, bus_addr};
    end else begin
      io_out[IO_WE_N]  = 1'b1;
      io_out[IO_STB_N] = 1'b1;
      if (state_q == EX_DATA) begin
        case (op_q)
          OP_STM: begin
            // High nibble is written as zero during D1.
            io_out[IO_WE_N] = 1'b0;
            if (phase_q == PH_D0) io_out[3:0] = a_q;
          end
          OP_OUT: begin
            io_out[IO_STB_N] = 1'b0;
            io_out[3:0]      = a_q;
          end
          OP_IN: io_out[IO_STB_N] = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_ADDR;
      state_q <= EX_OP;
      a_q     <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      rd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pc_q    <= '0;
      ea_q    <= '0;
      sp_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) stk_q[i] <= '0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      a_q     <= a_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      rd_q    <= rd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pc_q    <= pc_d;
      ea_q    <= ea_d;
      sp_q    <= sp_d;
      stk_q   <= stk_d;
    end
  end

`ifdef MOONBASE_TIMER_EN
  localparam int unsigned CntW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tf_q, tf_d;
  logic            wrap;

  always_comb begin
    wrap  = (cnt_q == CntW'(MAX_COUNT - 1));
    cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    // A wrap on the same edge as a tst clear leaves the flag set.
    tf_d  = wrap | (tf_q & ~tst_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tf_q  <= tf_d;
    end
  end

  assign tf_bit = tf_q;
`else
  logic [32:0] unused_cfg;
  assign unused_cfg = {tst_clr, 32'(MAX_COUNT)};
  assign tf_bit     = 1'b0;
`endif

  logic [1:0] unused_io_in;
  assign unused_io_in = io_in[7:6];

endmodule

// File: tb/tb_moonbase_cpu8_core.sv
// Directed self-checking bench for moonbase_cpu8_core with a 128x8 SRAM bus model.
module tb_moonbase_cpu8_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bus_nib = '0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {2'b00, bus_nib, rst_n, clk};

  moonbase_cpu8_core #(.MAX_COUNT(100)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [128];
  logic [6:0]  baddr = '0;
  bit          dph = 1'b0;
  logic [3:0]  io_rd_val = 4'h7;
  logic [3:0]  io_log [$];
  logic [6:0]  io_addr [$];
  int unsigned hit41 = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle of the SRAM/IO model, called just after each rising edge.
  task automatic bus_step();
    if (io_out[7]) begin
      baddr   = io_out[6:0];
      dph     = 1'b0;
      bus_nib = '0;
      if (baddr == 7'h41) hit41++;
    end else begin
      if (!io_out[5]) begin
        if (!dph) mem[baddr][3:0] = io_out[3:0];
        else      mem[baddr][7:4] = io_out[3:0];
        bus_nib = '0;
      end else if (!io_out[4]) begin
        if (!dph) begin
          io_log.push_back(io_out[3:0]);
          io_addr.push_back(baddr);
        end
        bus_nib = io_rd_val;
      end else begin
        bus_nib = dph ? mem[baddr][7:4] : mem[baddr][3:0];
      end
      dph = 1'b1;
    end
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_step();
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    #1;
    for (int unsigned i = 0; i < 128; i++) mem[i] = '0;
  endtask

  task automatic load(input logic [6:0] base, input logic [255:0] code, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) mem[base + 7'(i)] = {4'h0, code[4*(n-1-i) +: 4]};
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    io_log.delete();
    io_addr.delete();
    hit41 = 0;
    rst_n = 1'b1;
    #1;
    bus_step();
  endtask

  task automatic check_log(input string tag, input logic [63:0] exp, input int unsigned n,
                           input bit exact);
    if (exact) check({tag, "_count"}, io_log.size(), n);
    else       check({tag, "_enough"}, 32'(io_log.size() >= n), 1);
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("%s_io%0d", tag, i),
            (i < io_log.size()) ? {28'h0, io_log[i]} : 32'hffff_ffff,
            {28'h0, exp[4*(n-1-i) +: 4]});
  endtask

  function automatic logic [31:0] addr_at(input int unsigned k);
    return (k < io_addr.size()) ? {25'h0, io_addr[k]} : 32'hffff_ffff;
  endfunction

  initial begin
    // Reset and counter loop: X=0x80, IO-write 7(X), store 0(X), A=1, add 0(X), jne 0x05
    hold_reset();
    load(7'h00, 256'hc8080a7b08100d05f10, 19);
    mem[0] = 8'hac;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", io_out, 8'h80);
    start_test();
    check("rel_addr0", io_out, 8'h80);
    run(1);
    check("first_fetch_d0", io_out, 8'h30);
    check("first_fetch_addr", baddr, 7'h00);
    run(800);
    check_log("cnt", 64'h0123456789abcdef, 16, 1'b1);
    check("cnt_io_addr_wrap", addr_at(0), 7'h07);
    check("cnt_store_byte", mem[0], 8'h0f);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", io_out, 8'h80);

    // ALU ops against mem[0x60]=a, then A=mem, add #5, IO read of 7
    hold_reset();
    load(7'h00, 256'hc608c10a08c20a08c30a08c40a050a095a061a0f27, 42);
    mem[7'h60] = 8'h5a;
    start_test();
    run(300);
    check_log("alu", 64'h2e86af07, 8, 1'b1);
    check("alu_in_addr", addr_at(6), 7'h61);

    // Indexing through Y, swap, and 7-bit address wrap 0x7f+1
    hold_reset();
    load(7'h00, 256'hc2070c0058a859a97250a0c7f51a0f1d, 32);
    mem[7'h20] = 8'h38;
    mem[7'h21] = 8'h9c;
    start_test();
    run(300);
    check_log("idx", 64'h8c8c, 4, 1'b1);
    check("idx_addr_y1", addr_at(1), 7'h21);
    check("idx_addr_7f", addr_at(3), 7'h7f);

    // Nested call 0x49 -> 0x54, two returns, then jmp 0x5a <-> 0x41 forever
    hold_reset();
    load(7'h00, 256'h8cfc9a0f5a, 10);
    load(7'h41, 256'hf5a, 3);
    load(7'h49, 256'h91a0fd49173, 11);
    load(7'h54, 256'h91a073, 6);
    load(7'h5a, 256'hf41, 3);
    start_test();
    run(600);
    check_log("call", 64'hdef, 3, 1'b1);
    check("call_loop41", 32'(hit41 > 2), 1);

    // Five nested calls overflow the 4-deep stack; returns then cycle 4,3,2,1,4
    hold_reset();
    load(7'h00, 256'hf9080a073, 9);
    load(7'h10, 256'hfa081a073, 9);
    load(7'h20, 256'hfb082a073, 9);
    load(7'h30, 256'hfc083a073, 9);
    load(7'h40, 256'hfd084a073, 9);
    load(7'h50, 256'h73, 2);
    start_test();
    run(600);
    check_log("ovf", 64'h43214, 5, 1'b0);

    // tst after >100 clocks, then immediately again
    hold_reset();
    load(7'h00, 256'h8f9fd0278a078a0f0f, 18);
    start_test();
    run(400);
`ifdef MOONBASE_TIMER_EN
    check_log("tst", 64'h10, 2, 1'b1);
`else
    check_log("tst", 64'h00, 2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
